// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating counters,
// combinational fetch lookup, branch resolution/redirect and statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned INDEX_W = $clog2(ENTRIES),
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  input  logic              invalidate,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int unsigned TAG_W = 32 - INDEX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  // Sequential PC; the supervisor bit never receives a carry
  function automatic logic [31:0] seq_pc(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               unused_pc_bits;

  assign if_idx  = if_pc[INDEX_W+1:2];
  assign if_tag  = if_pc[31:INDEX_W+2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
  assign upd_tag = upd_pc[31:INDEX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Fetch lookup on pre-edge state, no bypass of a same-cycle update
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && cnt_q[if_idx][CNT_W-1];
    pred_target = pred_taken ? target_q[if_idx] : seq_pc(if_pc);
  end

  // Branch resolution: flush request and correct next PC
  always_comb begin
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    mispredict  = upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = upd_taken ? upd_target : seq_pc(upd_pc);
  end

  // BTB training; invalidate wins over a same-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else if (invalidate) begin
      valid_q <= '{default: 1'b0};
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          if (cnt_q[upd_idx] != CNT_MAX) begin
            cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_W'(1);
          end
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        cnt_q[upd_idx]    <= CNT_WEAK;
      end
    end
  end

  // Saturating hit / mispredict statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (upd_valid && upd_hit && (hit_count != '1)) begin
        hit_count <= hit_count + STAT_W'(1);
      end
      if (mispredict && (miss_count != '1)) begin
        miss_count <= miss_count + STAT_W'(1);
      end
    end
  end

endmodule
